error_vec_writer: RTL and testbench
===================================

# error_vec_writer

Downstream of the error locator in the decryption path. Snapshots the n-bit recovered error vector on `start` and streams it into the error-vector memory as w-bit words. Accumulates the Hamming weight of the vector and reports whether it equals t. The decapsulation controller uses that flag to decide between the real session key and the rejection key.

## Interface
- `m`, 13, field size exponent (passed through for consistency; unused internally)
- `n`, 6960, code length
- `t`, 119, required error weight
- `w`, 32, memory word width
- `DEPTH`, (n+w-1)/w = 218, words written per vector (localparam)
- `clk`  in  1  clock, all state updated on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse; error_in valid in the same cycle (driven from error locator `done`)
- `error_in`  in  n  recovered error vector; bit n-1 = position 0, bit 0 = position n-1
- `mem_wr_en`  out  1  write request
- `mem_wr_addr`  out  CLOG2(DEPTH)  word address
- `mem_wr_data`  out  w  word data
- `mem_wr_ready`  in  1  memory accepts the write this cycle
- `busy`  out  1  high from cycle after accepted start until done
- `done`  out  1  one-cycle pulse, results valid
- `weight`  out  CLOG2(n+1)  Hamming weight of the last vector
- `weight_ok`  out  1  weight == t

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: on `start`, latch error_in into the snapshot, clear weight, set addr=0, go to WRITE.
- WRITE: assert mem_wr_en. A beat is accepted when mem_wr_en & mem_wr_ready.
  - On accept: weight += popcount(word), addr += 1, advance the snapshot.
  - On the accept of word DEPTH-1: weight_ok <= (weight + popcount == t), go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Word k bit j = error position e = k*w+j = error_in[n-1-e]. Positions e ≥ n (last word bits 16..31 at default) are 0.
- mem_wr_data/mem_wr_addr are stable while mem_wr_en is high and ready is low.
- `start` outside IDLE is ignored and has no effect on the snapshot.
- weight/weight_ok hold their value until the next accepted start. weight clears to 0 at that start.
- Width: weight sized CLOG2(n+1) and cannot overflow. Popcount per word is CLOG2(w+1) bits, zero-extended.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; addr 0; snapshot 0.
- Reset mid-WRITE: write stream aborts immediately, no done, weight_ok=0. Memory contents are undefined and the consumer must not use them.
- Start accepted at edge 0. With ready held high, word k is written at cycles 1..DEPTH (cycle k+1). done at cycle DEPTH+1 (219 at defaults). Next start is accepted in cycle DEPTH+2.
- Each cycle with ready low adds exactly one cycle to done latency.
- One accepted word per cycle maximum. No bubbles when ready is high.

## Structure
- Shared decap package: CLOG2 macro, state enum, DEPTH/addr-width localparam functions.
- Snapshot is an n-bit register shifted left by w per accept, with the word taken bit-reversed from the top. No wide combinational mux.
- One sub-module `popcount_w` (parameter w, combinational adder tree, output CLOG2(w+1) bits), instantiated once on mem_wr_data.

## Test plan
- All-zero vector, ready=1 -> 218 writes of 0 at addr 0..217, done at cycle 219, weight=0, weight_ok=0.
- Exactly 119 errors including positions 0, 31, 32, 6959 -> word 0 bit 0 and bit 31 set, word 1 bit 0 set, word 217 bit 15 set, bits 16..31 of word 217 = 0. Result: weight=119, weight_ok=1.
- 118 errors and 120 errors -> weight 118/120, weight_ok=0.
- Random ready backpressure (50%) with a random 119-weight vector -> memory image matches the reference packing, done latency = 219 + stall cycles, data/addr stable during stalls.
- start pulsed again during WRITE with a different vector -> ignored; output matches the first vector.
- rst_n low at word 100 -> outputs 0 immediately, no done. A new start after release produces a complete, correct stream.

Source files
------------

// File: rtl/error_vec_writer_pkg.sv
// Shared decap definitions: writer FSM states and width/depth helpers.
package error_vec_writer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Number of w-bit words needed to hold an n-bit vector.
  function automatic int unsigned depth_f(input int unsigned n, input int unsigned w);
    return (n + w - 1) / w;
  endfunction

  function automatic int unsigned addr_w_f(input int unsigned n, input int unsigned w);
    int unsigned d;
    d = depth_f(n, w);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

  // Bits needed to count 0..v inclusive.
  function automatic int unsigned cnt_w_f(input int unsigned v);
    return (v > 0) ? $clog2(v + 1) : 1;
  endfunction

endpackage

// File: rtl/error_vec_writer_popcount_w.sv
// Combinational popcount of a w-bit word as a balanced binary adder tree.
module popcount_w
  import error_vec_writer_pkg::*;
#(
  parameter int unsigned w = 32
) (
  input  logic [w-1:0]             data,
  output logic [cnt_w_f(w)-1:0]    count
);

  localparam int unsigned CW  = cnt_w_f(w);
  localparam int unsigned LVL = (w > 1) ? $clog2(w) : 0;
  localparam int unsigned P   = 1 << LVL;

  // Level 0 holds the (zero-padded) input bits; each level halves the node count.
  for (genvar l = 0; l <= LVL; l++) begin : g_lvl
    logic [CW-1:0] s [P >> l];
    for (genvar i = 0; i < (P >> l); i++) begin : g_node
      if (l == 0) begin : g_leaf
        if (i < w) begin : g_bit
          assign s[i] = CW'(data[i]);
        end else begin : g_pad
          assign s[i] = '0;
        end
      end else begin : g_add
        assign s[i] = g_lvl[l-1].s[2*i] + g_lvl[l-1].s[2*i+1];
      end
    end
  end

  assign count = g_lvl[LVL].s[0];

endmodule

// File: rtl/error_vec_writer.sv
// Streams a snapshotted error vector into memory as w-bit words and reports
// whether its Hamming weight equals t.
module error_vec_writer
  import error_vec_writer_pkg::*;
#(
  parameter int unsigned m = 13,
  parameter int unsigned n = 6960,
  parameter int unsigned t = 119,
  parameter int unsigned w = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [n-1:0]                error_in,
  output logic                        mem_wr_en,
  output logic [addr_w_f(n, w)-1:0]   mem_wr_addr,
  output logic [w-1:0]                mem_wr_data,
  input  logic                        mem_wr_ready,
  output logic                        busy,
  output logic                        done,
  output logic [cnt_w_f(n)-1:0]       weight,
  output logic                        weight_ok
);

  localparam int unsigned DEPTH = depth_f(n, w);
  localparam int unsigned AW    = addr_w_f(n, w);
  localparam int unsigned WW    = cnt_w_f(n);
  localparam int unsigned PW    = cnt_w_f(w);

  state_e          state_q, state_d;
  logic [n-1:0]    snap_q, snap_d;
  logic [AW-1:0]   addr_d;
  logic [WW-1:0]   weight_d;
  logic            ok_d, en_d, busy_d, done_d;
  logic [PW-1:0]   pop_c;
  logic            accept_c;
  logic            unused_m;

  assign unused_m = ^32'(m);
  assign accept_c = mem_wr_en & mem_wr_ready;

  // Current word is the top w snapshot bits, bit-reversed so position k*w+j lands on bit j.
  for (genvar j = 0; j < w; j++) begin : g_word
    assign mem_wr_data[j] = snap_q[n-1-j];
  end

  popcount_w #(.w(w)) u_popcount (
    .data  (mem_wr_data),
    .count (pop_c)
  );

  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    addr_d   = mem_wr_addr;
    weight_d = weight;
    ok_d     = weight_ok;
    en_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = WRITE;
          snap_d   = error_in;
          addr_d   = '0;
          weight_d = '0;
          ok_d     = 1'b0;
        end
      end
      WRITE: begin
        if (accept_c) begin
          weight_d = weight + WW'(pop_c);
          snap_d   = snap_q << w;
          addr_d   = mem_wr_addr + AW'(1);
          if (mem_wr_addr == AW'(DEPTH - 1)) begin
            ok_d    = (weight_d == WW'(t));
            addr_d  = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    en_d   = (state_d == WRITE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      mem_wr_addr <= '0;
      weight      <= '0;
      weight_ok   <= 1'b0;
      mem_wr_en   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      mem_wr_addr <= addr_d;
      weight      <= weight_d;
      weight_ok   <= ok_d;
      mem_wr_en   <= en_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_error_vec_writer.sv
// Scoreboard bench for error_vec_writer: expected words queued at start, checked at write.
module tb_error_vec_writer;

  localparam int unsigned N     = 6960;
  localparam int unsigned W     = 32;
  localparam int unsigned T     = 119;
  localparam int unsigned DEPTH = 218;
  localparam int unsigned AW    = 8;
  localparam int unsigned WW    = 13;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } beat_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   error_in;
  logic           mem_wr_en;
  logic [AW-1:0]  mem_wr_addr;
  logic [W-1:0]   mem_wr_data;
  logic           mem_wr_ready;
  logic           busy;
  logic           done;
  logic [WW-1:0]  weight;
  logic           weight_ok;

  beat_t sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    stalls = 0;
  int    acc_cnt = 0;
  bit    mon_on = 1'b0;
  bit    rand_ready = 1'b0;

  error_vec_writer #(.m(13), .n(N), .t(T), .w(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .error_in     (error_in),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .done         (done),
    .weight       (weight),
    .weight_ok    (weight_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    mem_wr_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference packing: word k bit j = position k*W+j = error_in[N-1-position].
  task automatic push_words(input logic [N-1:0] v);
    beat_t b;
    int e;
    for (int k = 0; k < int'(DEPTH); k++) begin
      b.a = AW'(k);
      b.d = '0;
      for (int j = 0; j < int'(W); j++) begin
        e = k * int'(W) + j;
        if (e < int'(N)) b.d[j] = v[int'(N) - 1 - e];
      end
      sbq.push_back(b);
    end
  endtask

  function automatic logic [N-1:0] rand_vec(input logic [N-1:0] base, input int k);
    logic [N-1:0] v;
    int c;
    int p;
    v = base;
    c = $countones(base);
    while (c < k) begin
      p = int'($urandom_range(N - 1, 0));
      if (!v[p]) begin
        v[p] = 1'b1;
        c++;
      end
    end
    return v;
  endfunction

  // Write monitor: every presented beat (stalled or not) must match the queue head.
  always @(negedge clk) begin
    if (mon_on && rst_n && mem_wr_en) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0) begin
        chk("wr_addr", 64'(mem_wr_addr), 64'(sbq[0].a));
        chk("wr_data", 64'(mem_wr_data), 64'(sbq[0].d));
        if (mem_wr_ready) begin
          void'(sbq.pop_front());
          acc_cnt++;
        end else begin
          stalls++;
        end
      end
    end
  end

  task automatic run_vec(input logic [N-1:0] v, input int exp_w, input logic [N-1:0] v2,
                         input bit restart, input string tag);
    int s;
    int done_cyc;
    bit found;
    @(posedge clk);
    #1;
    stalls   = 0;
    start    = 1'b1;
    error_in = v;
    push_words(v);
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    found = 1'b0;
    done_cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) begin
        found    = 1'b1;
        done_cyc = cyc - s + 1;
        break;
      end
      if (i == 10) chk({tag, "_busy"}, 64'(busy), 64'(1));
      if (restart && i == 50) begin
        start    = 1'b1;
        error_in = v2;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(found), 64'(1));
    chk({tag, "_latency"}, 64'(done_cyc), 64'(int'(DEPTH) + 1 + stalls));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'(0));
    chk({tag, "_weight"}, 64'(weight), 64'(exp_w));
    chk({tag, "_weight_ok"}, 64'(weight_ok), 64'(exp_w == int'(T)));
    chk({tag, "_sb_drained"}, 64'(sbq.size()), 64'(0));
  endtask

  task automatic reset_mid(input logic [N-1:0] v);
    int a0;
    bit hit;
    @(posedge clk);
    #1;
    start    = 1'b1;
    error_in = v;
    push_words(v);
    a0 = acc_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit   = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (acc_cnt - a0 >= 100) begin
        hit = 1'b1;
        break;
      end
    end
    chk("rst_reach_w100", 64'(hit), 64'(1));
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_mid_en", 64'(mem_wr_en), 64'(0));
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    chk("rst_mid_addr", 64'(mem_wr_addr), 64'(0));
    chk("rst_mid_data", 64'(mem_wr_data), 64'(0));
    chk("rst_mid_weight", 64'(weight), 64'(0));
    chk("rst_mid_ok", 64'(weight_ok), 64'(0));
    sbq.delete();
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done), 64'(0));
    end
    rst_n  = 1'b1;
    mon_on = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    logic [N-1:0] v2;
    rst_n    = 1'b0;
    start    = 1'b0;
    error_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_en", 64'(mem_wr_en), 64'(0));
    chk("rst_addr", 64'(mem_wr_addr), 64'(0));
    chk("rst_data", 64'(mem_wr_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_weight", 64'(weight), 64'(0));
    chk("rst_ok", 64'(weight_ok), 64'(0));
    rst_n  = 1'b1;
    mon_on = 1'b1;

    v = '0;
    run_vec(v, 0, v, 1'b0, "zero");

    // Boundary positions 0, 31, 32 and N-1 plus random fill to weight T.
    v = '0;
    v[N-1-0]  = 1'b1;
    v[N-1-31] = 1'b1;
    v[N-1-32] = 1'b1;
    v[0]      = 1'b1;
    v = rand_vec(v, int'(T));
    run_vec(v, int'(T), v, 1'b0, "edges119");

    v = rand_vec('0, int'(T) - 1);
    run_vec(v, int'(T) - 1, v, 1'b0, "w118");
    v = rand_vec('0, int'(T) + 1);
    run_vec(v, int'(T) + 1, v, 1'b0, "w120");

    rand_ready = 1'b1;
    v = rand_vec('0, int'(T));
    run_vec(v, int'(T), v, 1'b0, "stall119");
    rand_ready = 1'b0;

    v  = rand_vec('0, int'(T));
    v2 = rand_vec('0, 50);
    run_vec(v, int'(T), v2, 1'b1, "restart");

    v = rand_vec('0, int'(T));
    reset_mid(v);
    v = '0;
    v[0] = 1'b1;
    v = rand_vec(v, int'(T));
    run_vec(v, int'(T), v, 1'b0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
